// File: rtl/psram_arbiter.sv
// psram_arbiter: shares the memCtrl PSRAM port between video (0), CPU (1) and loader (2),
// one byte access at a time, with a video starvation guard and a per-phase timeout.
module psram_arbiter #(
    parameter int VID_MAX = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clkSys,
    input  logic        rst,
    input  logic [2:0]  i_req,
    input  logic [2:0]  i_we,
    input  logic [71:0] i_addr,
    input  logic [23:0] i_wdata,
    input  logic [2:0]  i_bank,
    output logic [2:0]  o_gnt,
    output logic [2:0]  o_done,
    output logic [2:0]  o_err,
    output logic [7:0]  o_rdata,
    output logic [1:0]  o_owner,
    output logic        mc_cs_n,
    output logic        mc_write,
    output logic [23:0] mc_addr,
    output logic        mc_bank,
    output logic [7:0]  mc_wdata,
    input  logic        mc_busy,
    input  logic        mc_dataReady,
    input  logic [7:0]  mc_rdata,
    input  logic        mc_idle
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int VW = $clog2(VID_MAX + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACC, WAIT_DONE, RECOVER} state_t;

    state_t          r_state, w_state;
    logic [TW-1:0]   r_timer, w_timer;
    logic [VW-1:0]   r_vid_cnt, w_vid_cnt;
    logic [1:0]      r_rr, w_rr;
    logic [2:0]      w_gnt, w_done, w_err, w_own_oh;
    logic [7:0]      w_rdata, w_wdata;
    logic [1:0]      w_owner, w_win;
    logic            w_cs_n, w_write, w_bank;
    logic [23:0]     w_addr;
    logic            w_arb, w_vid_block, w_tmo, w_cmp;

    assign w_arb       = (r_state == IDLE) && mc_idle && !mc_busy && (i_req != 3'b000);
    assign w_vid_block = (r_vid_cnt == VW'(VID_MAX)) && (i_req[1] | i_req[2]);
    assign w_win       = (i_req[0] && !w_vid_block) ? 2'd0 :
                         (i_req[1] && i_req[2])     ? r_rr :
                         i_req[1]                   ? 2'd1 : 2'd2;
    // the compare fires one cycle early so the registered pulse lands after TIMEOUT cycles
    assign w_tmo       = r_timer == TW'(TIMEOUT - 1);
    assign w_cmp       = !mc_busy && (mc_write || mc_dataReady);
    assign w_own_oh    = 3'b001 << o_owner;

    always_comb begin
        w_state   = r_state;
        w_timer   = r_timer;
        w_vid_cnt = r_vid_cnt;
        w_rr      = r_rr;
        w_gnt     = 3'b000;
        w_done    = 3'b000;
        w_err     = 3'b000;
        w_rdata   = o_rdata;
        w_owner   = o_owner;
        w_cs_n    = mc_cs_n;
        w_write   = mc_write;
        w_addr    = mc_addr;
        w_bank    = mc_bank;
        w_wdata   = mc_wdata;
        case (r_state)
            IDLE: if (w_arb) begin
                w_gnt     = 3'b001 << w_win;
                w_owner   = w_win;
                w_cs_n    = 1'b0;
                w_write   = i_we[w_win];
                w_bank    = i_bank[w_win];
                w_addr    = (w_win == 2'd0) ? i_addr[23:0]  : (w_win == 2'd1) ? i_addr[47:24]  : i_addr[71:48];
                w_wdata   = (w_win == 2'd0) ? i_wdata[7:0]  : (w_win == 2'd1) ? i_wdata[15:8]  : i_wdata[23:16];
                w_timer   = '0;
                w_state   = ISSUE;
                w_vid_cnt = (w_win != 2'd0) ? '0 :
                            (r_vid_cnt == VW'(VID_MAX)) ? r_vid_cnt : r_vid_cnt + 1'b1;
                w_rr      = (w_win == 2'd0) ? r_rr : (w_win == 2'd1) ? 2'd2 : 2'd1;
            end
            ISSUE: begin
                w_cs_n  = 1'b1;
                w_state = WAIT_ACC;
            end
            WAIT_ACC: begin
                if (mc_busy) begin
                    w_state = WAIT_DONE;
                    w_timer = '0;
                end else if (w_tmo) begin
                    w_done  = w_own_oh;
                    w_err   = w_own_oh;
                    w_state = RECOVER;
                end else
                    w_timer = r_timer + 1'b1;
            end
            WAIT_DONE: begin
                if (w_cmp) begin
                    w_done  = w_own_oh;
                    w_rdata = mc_write ? o_rdata : mc_rdata;
                    w_owner = 2'd3;
                    w_state = IDLE;
                end else if (w_tmo) begin
                    w_done  = w_own_oh;
                    w_err   = w_own_oh;
                    w_state = RECOVER;
                end else
                    w_timer = r_timer + 1'b1;
            end
            RECOVER: if (mc_idle && !mc_busy) begin
                w_owner = 2'd3;
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clkSys or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_vid_cnt <= '0;
            r_rr      <= 2'd1;
            o_gnt     <= 3'b000;
            o_done    <= 3'b000;
            o_err     <= 3'b000;
            o_rdata   <= 8'h00;
            o_owner   <= 2'd3;
            mc_cs_n   <= 1'b1;
            mc_write  <= 1'b0;
            mc_addr   <= 24'h0;
            mc_bank   <= 1'b0;
            mc_wdata  <= 8'h00;
        end else begin
            r_state   <= w_state;
            r_timer   <= w_timer;
            r_vid_cnt <= w_vid_cnt;
            r_rr      <= w_rr;
            o_gnt     <= w_gnt;
            o_done    <= w_done;
            o_err     <= w_err;
            o_rdata   <= w_rdata;
            o_owner   <= w_owner;
            mc_cs_n   <= w_cs_n;
            mc_write  <= w_write;
            mc_addr   <= w_addr;
            mc_bank   <= w_bank;
            mc_wdata  <= w_wdata;
        end
    end
endmodule

// File: tb/tb_psram_arbiter.sv
// tb_psram_arbiter: directed table of single-port accesses against a small memCtrl model,
// plus contention, round-robin, timeout/recover and reset-mid-read sequences.
module tb_psram_arbiter;
    logic        clkSys = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  i_req, i_we, i_bank;
    logic [71:0] i_addr;
    logic [23:0] i_wdata;
    logic [2:0]  o_gnt, o_done, o_err;
    logic [7:0]  o_rdata;
    logic [1:0]  o_owner;
    logic        mc_cs_n, mc_write, mc_bank;
    logic [23:0] mc_addr;
    logic [7:0]  mc_wdata;
    logic        mc_busy, mc_dataReady, mc_idle;
    logic [7:0]  mc_rdata;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clkSys = ~clkSys;

    psram_arbiter #(.VID_MAX(4), .TIMEOUT(255)) dut (
        .clkSys(clkSys), .rst(rst), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_bank(i_bank), .o_gnt(o_gnt), .o_done(o_done), .o_err(o_err),
        .o_rdata(o_rdata), .o_owner(o_owner), .mc_cs_n(mc_cs_n), .mc_write(mc_write),
        .mc_addr(mc_addr), .mc_bank(mc_bank), .mc_wdata(mc_wdata), .mc_busy(mc_busy),
        .mc_dataReady(mc_dataReady), .mc_rdata(mc_rdata), .mc_idle(mc_idle)
    );

    // memCtrl model: latch on cs, busy for a few cycles, read data with dataReady as busy drops
    logic [7:0] mem [0:255];
    logic [1:0] m_st = 2'd0;
    logic [2:0] m_cnt = 3'd0;
    logic       m_busy = 1'b0, m_rdy = 1'b0, m_we = 1'b0;
    logic [7:0] m_rdata = 8'h00, m_a = 8'h00, m_d = 8'h00;
    logic       dead = 1'b0, idle_hold = 1'b0;

    assign mc_busy      = m_busy;
    assign mc_dataReady = m_rdy;
    assign mc_rdata     = m_rdata;
    assign mc_idle      = (m_st == 2'd0) && !idle_hold;

    always @(posedge clkSys) begin
        m_rdy <= 1'b0;
        if (!rst) begin
            m_st   <= 2'd0;
            m_busy <= 1'b0;
        end else if (m_st == 2'd0) begin
            if (!mc_cs_n && !dead) begin
                m_st <= 2'd1;
                m_we <= mc_write;
                m_a  <= mc_addr[7:0];
                m_d  <= mc_wdata;
            end
        end else if (m_st == 2'd1) begin
            m_busy <= 1'b1;
            m_cnt  <= 3'd2;
            m_st   <= 2'd2;
        end else if (m_cnt == 3'd0) begin
            m_busy <= 1'b0;
            m_st   <= 2'd0;
            if (m_we) mem[m_a] <= m_d;
            else begin
                m_rdy   <= 1'b1;
                m_rdata <= mem[m_a];
            end
        end else
            m_cnt <= m_cnt - 3'd1;
    end

    typedef struct {
        logic [1:0]  port;
        logic        we;
        logic [23:0] addr;
        logic [7:0]  wdata;
        logic        bank;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    // which: 0 = wait for a grant, 1 = wait for a done; cyc = negedges waited
    task automatic wait_sig(input int which, input int bound, output int cyc);
        cyc = 0;
        do begin
            @(negedge clkSys);
            cyc++;
        end while (((which == 0) ? o_gnt : o_done) == 3'b000 && cyc < bound);
    endtask

    task automatic do_reset();
        @(negedge clkSys);
        rst = 1'b0;
        i_req = 3'b000;
        repeat (2) @(negedge clkSys);
        rst = 1'b1;
    endtask

    task automatic set_port(input int p, input logic we, input logic [23:0] a, input logic [7:0] d, input logic b);
        i_we[p] = we;
        i_bank[p] = b;
        i_addr[24*p +: 24] = a;
        i_wdata[8*p +: 8] = d;
    endtask

    task automatic run_txn(input int p, input logic we, input logic [23:0] a, input logic [7:0] d,
                           input logic b, input logic [7:0] exp_rd);
        int c;
        @(negedge clkSys);
        set_port(p, we, a, d, b);
        i_req = 3'b001 << p;
        wait_sig(0, 40, c);
        chk($sformatf("gnt p%0d", p), {29'd0, o_gnt}, 32'd1 << p);
        chk("owner at gnt", {30'd0, o_owner}, p);
        chk("cs low", {31'd0, mc_cs_n}, 0);
        chk("mc_addr", {8'd0, mc_addr}, {8'd0, a});
        chk("mc_write", {31'd0, mc_write}, {31'd0, we});
        chk("mc_bank", {31'd0, mc_bank}, {31'd0, b});
        if (we) chk("mc_wdata", {24'd0, mc_wdata}, {24'd0, d});
        i_req = 3'b000;
        @(negedge clkSys);
        chk("cs one cycle", {31'd0, mc_cs_n}, 1);
        chk("gnt pulse", {29'd0, o_gnt}, 0);
        wait_sig(1, 60, c);
        chk($sformatf("done p%0d", p), {29'd0, o_done}, 32'd1 << p);
        chk("err clear", {29'd0, o_err}, 0);
        if (!we) chk("rdata", {24'd0, o_rdata}, {24'd0, exp_rd});
        @(negedge clkSys);
        chk("done pulse", {29'd0, o_done}, 0);
        chk("owner free", {30'd0, o_owner}, 3);
        if (!we) chk("rdata held", {24'd0, o_rdata}, {24'd0, exp_rd});
    endtask

    task automatic run_order(input int n, input int exp_seq [12], input string nm);
        int c;
        for (int k = 0; k < n; k++) begin
            wait_sig(0, 40, c);
            chk($sformatf("%s gnt %0d", nm, k), {29'd0, o_gnt}, 32'd1 << exp_seq[k]);
            chk($sformatf("%s owner %0d", nm, k), {30'd0, o_owner}, exp_seq[k]);
        end
        i_req = 3'b000;
        wait_sig(1, 60, c);
        repeat (3) @(negedge clkSys);
    endtask

    initial begin
        int c, gseen, nd;
        int cont_seq [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0};
        int rr_seq [12]   = '{1, 2, 1, 2, 1, 2, 0, 0, 0, 0, 0, 0};
        vecs[0] = '{2'd1, 1'b1, 24'h000002, 8'hCA, 1'b0, 8'h00};
        vecs[1] = '{2'd1, 1'b0, 24'h000002, 8'h00, 1'b0, 8'hCA};
        vecs[2] = '{2'd0, 1'b1, 24'h000010, 8'h3C, 1'b1, 8'h00};
        vecs[3] = '{2'd2, 1'b1, 24'h123411, 8'h96, 1'b1, 8'h00};
        vecs[4] = '{2'd0, 1'b0, 24'h000011, 8'h00, 1'b0, 8'h96};
        vecs[5] = '{2'd2, 1'b0, 24'hABCD10, 8'h00, 1'b1, 8'h3C};
        vecs[6] = '{2'd1, 1'b0, 24'h000002, 8'h00, 1'b0, 8'hCA};
        i_req = 3'b000; i_we = 3'b000; i_bank = 3'b000; i_addr = '0; i_wdata = '0;
        repeat (2) @(negedge clkSys);
        chk("rst gnt", {29'd0, o_gnt}, 0);
        chk("rst done", {29'd0, o_done}, 0);
        chk("rst err", {29'd0, o_err}, 0);
        chk("rst rdata", {24'd0, o_rdata}, 0);
        chk("rst owner", {30'd0, o_owner}, 3);
        chk("rst cs_n", {31'd0, mc_cs_n}, 1);
        chk("rst write", {31'd0, mc_write}, 0);
        chk("rst addr", {8'd0, mc_addr}, 0);
        chk("rst bank", {31'd0, mc_bank}, 0);
        chk("rst wdata", {24'd0, mc_wdata}, 0);
        rst = 1'b1;

        for (int i = 0; i < 7; i++)
            run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].bank, vecs[i].exp_rd);

        // all three ports request continuously: video capped at four in a row, CPU/loader alternate
        do_reset();
        set_port(0, 1'b0, 24'h000002, 8'h00, 1'b0);
        set_port(1, 1'b0, 24'h000010, 8'h00, 1'b0);
        set_port(2, 1'b0, 24'h000011, 8'h00, 1'b0);
        i_req = 3'b111;
        run_order(12, cont_seq, "contend");

        do_reset();
        i_req = 3'b110;
        run_order(6, rr_seq, "rr");

        // memCtrl never goes busy: access times out, then arbiter waits for memCtrl idle
        do_reset();
        dead = 1'b1;
        @(negedge clkSys);
        set_port(1, 1'b1, 24'h000030, 8'h55, 1'b0);
        i_req = 3'b010;
        wait_sig(0, 40, c);
        chk("tmo gnt", {29'd0, o_gnt}, 32'b010);
        i_req = 3'b000;
        idle_hold = 1'b1;
        wait_sig(1, 400, c);
        chk("tmo done", {29'd0, o_done}, 32'b010);
        chk("tmo err", {29'd0, o_err}, 32'b010);
        chk("tmo latency in range", {31'd0, c >= 250 && c <= 262}, 1);
        chk("tmo rdata unchanged", {24'd0, o_rdata}, 0);
        set_port(2, 1'b1, 24'h000020, 8'h77, 1'b0);
        i_req = 3'b100;
        gseen = 0;
        repeat (10) begin
            @(negedge clkSys);
            if (o_gnt != 3'b000 || o_done != 3'b000) gseen++;
        end
        chk("recover no gnt", gseen, 0);
        chk("recover owner", {30'd0, o_owner}, 1);
        dead = 1'b0;
        idle_hold = 1'b0;
        run_txn(2, 1'b1, 24'h000020, 8'h77, 1'b0, 8'h00);
        run_txn(2, 1'b0, 24'h000020, 8'h00, 1'b0, 8'h77);

        // reset during WAIT_DONE of a read
        do_reset();
        run_txn(1, 1'b1, 24'h000005, 8'h5A, 1'b0, 8'h00);
        @(negedge clkSys);
        set_port(1, 1'b0, 24'h000005, 8'h00, 1'b0);
        i_req = 3'b010;
        wait_sig(0, 40, c);
        chk("rmr gnt", {29'd0, o_gnt}, 32'b010);
        i_req = 3'b000;
        c = 0;
        while (!mc_busy && c < 20) begin
            @(negedge clkSys);
            c++;
        end
        chk("rmr busy seen", {31'd0, mc_busy}, 1);
        @(negedge clkSys);
        rst = 1'b0;
        #1;
        chk("rmr owner", {30'd0, o_owner}, 3);
        chk("rmr cs_n", {31'd0, mc_cs_n}, 1);
        chk("rmr addr", {8'd0, mc_addr}, 0);
        chk("rmr done", {29'd0, o_done}, 0);
        nd = 0;
        repeat (3) begin
            @(negedge clkSys);
            nd = nd | {29'd0, o_done};
        end
        rst = 1'b1;
        repeat (8) begin
            @(negedge clkSys);
            nd = nd | {29'd0, o_done};
        end
        chk("rmr no done", nd, 0);
        run_txn(1, 1'b0, 24'h000005, 8'h00, 1'b0, 8'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end
endmodule
